// File: rtl/PKG_pwm.sv
// -----------------------------------------------------------------------------
// PKG_pwm
// Shared definitions for the carrier start sequencer:
//   `SEQDLY_WIDTH : default width of the stagger delay between channel slots.
//   _seq_state    : sequencer FSM state encoding, also driven out on the
//                   3-bit 'state' port of carr_start_sequencer.
// -----------------------------------------------------------------------------
`ifndef SEQDLY_WIDTH
`define SEQDLY_WIDTH 16
`endif

package PKG_pwm;

    localparam int SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        IDLE     = 3'd0,
        STAGGER  = 3'd1,
        RUN      = 3'd2,
        STOPPING = 3'd3
    } _seq_state;

endpackage

// File: rtl/stagger_timer.sv
// -----------------------------------------------------------------------------
// stagger_timer
// Reloadable down-counter that paces the channel slots of the sequencer.
// A load writes reload_i into the counter; otherwise it counts down and
// saturates at zero, so an all-ones reload never wraps.
//
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset, clears the counter
//   load_i    : load reload_i into the counter this cycle
//   reload_i  : reload value (number of idle cycles before the next tick)
//   tick_o    : high while the counter is zero
// -----------------------------------------------------------------------------
module stagger_timer #(
    parameter int DLY_WIDTH = `SEQDLY_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [DLY_WIDTH-1:0] reload_i,
    output logic                 tick_o
);

    logic [DLY_WIDTH-1:0] cnt_q;
    logic [DLY_WIDTH-1:0] cnt_d;

    always_comb begin
        // NOTE: next-state gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = reload_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DLY_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/carr_start_sequencer.sv
// -----------------------------------------------------------------------------
// carr_start_sequencer
// Turns on the pwm_onoff drive of NCARR carrier channels one slot at a time,
// with stagger_dly idle cycles between consecutive slots, and turns them off
// again either gracefully (each channel at its own carrier maskevent) or
// immediately on abort.
//
// Ports:
//   clk            : clock, rising edge
//   reset          : synchronous active-high reset
//   start          : start request (honoured only in IDLE)
//   stop           : graceful stop request (STAGGER / RUN)
//   abort          : immediate stop, highest priority
//   chan_en        : channels to start, latched at start
//   stagger_dly    : idle cycles between slots, latched at start
//   maskevent_in   : per-channel maskevent pulses, used only in STOPPING
//   pwm_onoff_out  : per-channel pwm on/off drive (registered)
//   busy           : state is not IDLE
//   running        : state is RUN
//   done           : one-cycle pulse when a graceful stop completes
//   state          : current FSM state (_seq_state encoding)
// -----------------------------------------------------------------------------
module carr_start_sequencer
    import PKG_pwm::*;
#(
    parameter int NCARR     = 8,
    parameter int DLY_WIDTH = `SEQDLY_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   abort,
    input  logic [NCARR-1:0]       chan_en,
    input  logic [DLY_WIDTH-1:0]   stagger_dly,
    input  logic [NCARR-1:0]       maskevent_in,
    output logic [NCARR-1:0]       pwm_onoff_out,
    output logic                   busy,
    output logic                   running,
    output logic                   done,
    output logic [SEQ_STATE_W-1:0] state
);

    localparam int IDX_W = (NCARR > 1) ? $clog2(NCARR) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCARR - 1);

    _seq_state            state_q;
    logic [NCARR-1:0]     pwm_q;
    logic                 done_q;
    logic [NCARR-1:0]     chan_q;     // shadow of chan_en taken at start
    logic [DLY_WIDTH-1:0] dly_q;      // shadow of stagger_dly taken at start
    logic [IDX_W-1:0]     idx_q;      // last slot issued

    logic                 start_ok;
    logic                 last_slot;
    logic                 issue;
    logic                 tick;
    logic                 timer_load;
    logic [DLY_WIDTH-1:0] timer_reload;
    logic [IDX_W-1:0]     next_idx;

    assign start_ok  = (state_q == IDLE) && start && !stop && !abort && (chan_en != '0);
    assign last_slot = (idx_q == LAST_IDX);
    assign next_idx  = idx_q + IDX_W'(1);

    // A stop or abort sampled on the same edge as a pending slot wins:
    // the slot is not issued.
    assign issue = (state_q == STAGGER) && !abort && !stop && !last_slot && tick;

    // Slot 0 is issued on the start edge itself, so the first reload comes
    // straight from the input; later reloads use the latched delay.
    assign timer_load   = start_ok || issue;
    assign timer_reload = (state_q == IDLE) ? stagger_dly : dly_q;

    stagger_timer #(
        .DLY_WIDTH (DLY_WIDTH)
    ) u_stagger_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (timer_load),
        .reload_i (timer_reload),
        .tick_o   (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pwm_q   <= '0;
            done_q  <= 1'b0;
            chan_q  <= '0;
            dly_q   <= '0;
            idx_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != IDLE)) begin
                pwm_q   <= '0;
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_ok) begin
                            chan_q  <= chan_en;
                            dly_q   <= stagger_dly;
                            idx_q   <= '0;
                            pwm_q   <= chan_en & NCARR'(1);
                            state_q <= STAGGER;
                        end
                    end
                    STAGGER: begin
                        if (stop) begin
                            state_q <= STOPPING;
                        end else if (last_slot) begin
                            state_q <= RUN;
                        end else if (tick) begin
                            // Disabled channels still take their slot.
                            idx_q           <= next_idx;
                            pwm_q[next_idx] <= chan_q[next_idx];
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            state_q <= STOPPING;
                        end
                    end
                    STOPPING: begin
                        if (pwm_q == '0) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            pwm_q <= pwm_q & ~maskevent_in;
                        end
                    end
                    default: begin
                        pwm_q   <= '0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign pwm_onoff_out = pwm_q;
    assign busy          = (state_q != IDLE);
    assign running       = (state_q == RUN);
    assign done          = done_q;
    assign state         = state_q;

endmodule

// File: tb/tb_carr_start_sequencer.sv
// -----------------------------------------------------------------------------
// tb_carr_start_sequencer
// Self-checking bench: a timeline model (slot i of a run started in cycle t0
// turns on in cycle t0+1+i*(D+1)) predicts every output each cycle, and
// directed scenarios pin that model with hand-computed literals. A random
// phase then exercises start/stop/abort/reset/maskevent interleavings.
// -----------------------------------------------------------------------------
module tb_carr_start_sequencer;
    import PKG_pwm::*;

    localparam int N = 8;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         stop;
    logic         abort;
    logic [N-1:0] chan_en;
    logic [W-1:0] dly;
    logic [N-1:0] maskevent_in;
    logic [N-1:0] pwm;
    logic         busy;
    logic         running;
    logic         done;
    logic [2:0]   state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    carr_start_sequencer #(
        .NCARR     (N),
        .DLY_WIDTH (W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .abort         (abort),
        .chan_en       (chan_en),
        .stagger_dly   (dly),
        .maskevent_in  (maskevent_in),
        .pwm_onoff_out (pwm),
        .busy          (busy),
        .running       (running),
        .done          (done),
        .state         (state)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    _seq_state    m_state;
    logic [N-1:0] m_pwm;
    logic [N-1:0] m_c;
    logic         m_done;
    longint       m_t0;
    longint       m_d;
    longint       mcyc;

    // Channels whose slot has come up by cycle k in the current run.
    function automatic logic [N-1:0] issued_by(input longint k);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i] = m_c[i] && (k >= m_t0 + 1 + longint'(i) * (m_d + 1));
        end
        return r;
    endfunction

    initial begin : model
        m_state = IDLE;
        m_pwm   = '0;
        m_c     = '0;
        m_done  = 1'b0;
        m_t0    = 0;
        m_d     = 0;
        mcyc    = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check($sformatf("c%0d_pwm", mcyc), pwm, m_pwm);
            check($sformatf("c%0d_state", mcyc), state, m_state);
            check($sformatf("c%0d_busy", mcyc), busy, m_state != IDLE);
            check($sformatf("c%0d_running", mcyc), running, m_state == RUN);
            check($sformatf("c%0d_done", mcyc), done, m_done);
            // predict the next cycle from the inputs sampled at the coming edge
            m_done = 1'b0;
            if (reset) begin
                m_state = IDLE;
                m_pwm   = '0;
                m_c     = '0;
            end else if (abort && m_state != IDLE) begin
                m_state = IDLE;
                m_pwm   = '0;
            end else begin
                case (m_state)
                    IDLE: if (start && !stop && chan_en != '0) begin
                        m_t0    = mcyc;
                        m_c     = chan_en;
                        m_d     = longint'(dly);
                        m_pwm   = issued_by(mcyc + 1);
                        m_state = STAGGER;
                    end
                    STAGGER: begin
                        if (stop) m_state = STOPPING;
                        else if (mcyc + 1 >= m_t0 + 2 + longint'(N - 1) * (m_d + 1)) m_state = RUN;
                        else m_pwm = issued_by(mcyc + 1);
                    end
                    RUN: if (stop) m_state = STOPPING;
                    default: begin
                        if (m_pwm == '0) begin
                            m_state = IDLE;
                            m_done  = 1'b1;
                        end else begin
                            m_pwm = m_pwm & ~maskevent_in;
                        end
                    end
                endcase
            end
            mcyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [N-1:0] e;

    initial begin : stim
        reset = 1'b1; start = 1'b0; stop = 1'b0; abort = 1'b0;
        chan_en = '0; dly = '0; maskevent_in = '0;
        step(3);
        check("rst_pwm", pwm, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_running", running, 1'b0);
        check("rst_state", state, IDLE);
        reset = 1'b0;
        step(2);

        // all channels, D=2: bit i at offset 1+3i, RUN at offset 23
        chan_en = 8'hFF; dly = 16'd2; start = 1'b1;
        step(1); start = 1'b0;
        check("d2_off1", pwm, 8'h01);
        chan_en = 8'h00; dly = 16'd9;          // ignored outside IDLE
        step(2);  check("d2_off3", pwm, 8'h01);
        step(1);  check("d2_off4", pwm, 8'h03);
        step(18); check("d2_off22", pwm, 8'hFF);
        check("d2_off22_run", running, 1'b0);
        step(1);  check("d2_off23_run", running, 1'b1);

        // start while RUN is ignored
        chan_en = 8'h0F; start = 1'b1;
        step(1); start = 1'b0;
        check("run_start_state", state, RUN);
        check("run_start_pwm", pwm, 8'hFF);

        // graceful stop, one maskevent per cycle
        stop = 1'b1; step(1); stop = 1'b0;
        check("stop_state", state, STOPPING);
        for (int i = 0; i < N; i++) begin
            maskevent_in = 8'h01 << i;
            step(1);
            maskevent_in = '0;
            e = 8'hFF << (i + 1);
            check($sformatf("mask_b%0d", i), pwm, e);
        end
        check("last_busy", busy, 1'b1);
        check("last_done", done, 1'b0);
        step(1);
        check("done_pulse", done, 1'b1);
        check("done_busy", busy, 1'b0);
        step(1);
        check("done_gone", done, 1'b0);

        // ignored requests in IDLE
        chan_en = 8'h00; start = 1'b1; step(1);
        check("zero_en_state", state, IDLE);
        chan_en = 8'hFF; stop = 1'b1; step(1);
        check("start_stop_state", state, IDLE);
        start = 1'b0; step(1);
        check("stop_alone_state", state, IDLE);
        stop = 1'b0;
        check("idle_pwm", pwm, 8'h00);

        // sparse enables, D=0
        chan_en = 8'hA5; dly = 16'd0; start = 1'b1;
        step(1); start = 1'b0; chan_en = 8'hFF;
        check("a5_off1", pwm, 8'h01);
        step(1); check("a5_off2", pwm, 8'h01);
        step(1); check("a5_off3", pwm, 8'h05);
        step(3); check("a5_off6", pwm, 8'h25);
        step(2); check("a5_off8", pwm, 8'hA5);
        check("a5_off8_run", running, 1'b0);
        step(1); check("a5_off9_run", running, 1'b1);

        // abort in RUN
        abort = 1'b1; step(1); abort = 1'b0;
        check("abort_pwm", pwm, 8'h00);
        check("abort_state", state, IDLE);
        check("abort_done", done, 1'b0);
        step(1); check("abort_done2", done, 1'b0);

        // stop after three slots
        chan_en = 8'hFF; dly = 16'd2; start = 1'b1;
        step(1); start = 1'b0;
        step(6); check("ss_off7", pwm, 8'h07);
        stop = 1'b1; step(1); stop = 1'b0;
        check("ss_state", state, STOPPING);
        step(10); check("ss_hold", pwm, 8'h07);
        maskevent_in = 8'h05; step(1);
        check("ss_m05", pwm, 8'h02);
        maskevent_in = 8'hF8; step(1);
        check("ss_mf8", pwm, 8'h02);
        maskevent_in = 8'h02; step(1); maskevent_in = '0;
        check("ss_m02", pwm, 8'h00);
        step(1); check("ss_done", done, 1'b1);

        // reset in the cycle before bit 4 would appear (D=1 -> offset 9)
        chan_en = 8'hFF; dly = 16'd1; start = 1'b1;
        step(1); start = 1'b0;
        step(7); check("rs_off8", pwm, 8'h0F);
        reset = 1'b1; step(1); reset = 1'b0;
        check("rs_pwm", pwm, 8'h00);
        check("rs_state", state, IDLE);
        check("rs_done", done, 1'b0);

        // maximum delay does not wrap
        chan_en = 8'h03; dly = 16'hFFFF; start = 1'b1;
        step(1); start = 1'b0;
        step(65535); check("max_off65536", pwm, 8'h01);
        step(1);     check("max_off65537", pwm, 8'h03);
        abort = 1'b1; step(1); abort = 1'b0;

        // random interleavings
        for (int c = 0; c < 4000; c++) begin
            start        = ($urandom_range(0, 3) == 0);
            stop         = ($urandom_range(0, 39) == 0);
            abort        = ($urandom_range(0, 99) == 0);
            reset        = ($urandom_range(0, 499) == 0);
            chan_en      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            dly          = 16'($urandom_range(0, 4));
            maskevent_in = 8'($urandom) & 8'($urandom);
            step(1);
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0; abort = 1'b0; maskevent_in = '0;
        step(2);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/carr_start_sequencer.md
CARR_START_SEQUENCER -- requirements
Module: carr_start_sequencer

Interface
REQ-001 SHALL have parameter NCARR, default 8, number of carrier channels sequenced.
REQ-002 SHALL have parameter DLY_WIDTH, default `SEQDLY_WIDTH (16), width of the stagger delay.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  start request; sampled every cycle.
REQ-006 SHALL have port stop  input  1  graceful stop request; sampled every cycle.
REQ-007 SHALL have port abort  input  1  immediate stop; sampled every cycle.
REQ-008 SHALL have port chan_en  input  NCARR  channels to be started.
REQ-009 SHALL have port stagger_dly  input  DLY_WIDTH  idle cycles between consecutive channel slots.
REQ-010 SHALL have port maskevent_in  input  NCARR  per-channel carrier maskevent pulses.
REQ-011 SHALL have port pwm_onoff_out  output  NCARR  per-channel pwm_onoff drive, registered.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port running  output  1  high exactly while state is RUN.
REQ-014 SHALL have port done  output  1  one-cycle pulse on graceful stop completion.
REQ-015 SHALL have port state  output  3  current FSM state, encoded as _seq_state.

Function
REQ-016 SHALL implement FSM states IDLE, STAGGER, RUN, STOPPING.
REQ-017 In IDLE, start=1 with chan_en!=0 and stop=0 and abort=0 SHALL latch chan_en and stagger_dly into shadow registers (D = latched delay), set slot index to 0, and enter STAGGER next cycle.
REQ-018 In IDLE, start with chan_en==0, start together with stop, and stop alone SHALL be ignored.
REQ-019 For start sampled in cycle t, pwm_onoff_out[i] SHALL first read 1 in cycle t+1+i*(D+1) when shadow chan_en[i]=1, and stay 0 otherwise; disabled channels still consume their slot.
REQ-020 After slot NCARR-1 is issued, the FSM SHALL enter RUN in the following cycle, t+2+(NCARR-1)*(D+1).
REQ-021 Slot arithmetic SHALL use a DLY_WIDTH reload down-counter and a $clog2(NCARR) index; D=all-ones SHALL not wrap or overflow.
REQ-022 Changes to chan_en and stagger_dly outside IDLE SHALL have no effect until the next start.
REQ-023 start SHALL be ignored in every state other than IDLE.
REQ-024 stop in STAGGER or RUN SHALL enter STOPPING next cycle; channels not yet issued stay 0.
REQ-025 In STOPPING, maskevent_in[i]=1 in cycle u SHALL clear pwm_onoff_out[i] in cycle u+1; maskevent on bits already 0 is ignored.
REQ-026 When all pwm_onoff_out bits are 0 in STOPPING, the FSM SHALL enter IDLE next cycle with done=1 for that one cycle; this includes entering STOPPING with no channel on.
REQ-027 abort in any non-IDLE state SHALL clear all pwm_onoff_out and enter IDLE next cycle without a done pulse; abort has priority over stop and start.
REQ-028 maskevent_in SHALL be ignored outside STOPPING.

Reset
REQ-029 reset=1 SHALL force IDLE, pwm_onoff_out=0, busy=0, running=0, done=0, and zero the shadow registers, slot counter and index, including mid-STAGGER or mid-STOPPING; reset overrides all inputs.

Structure
REQ-030 typedef enum _seq_state {IDLE, STAGGER, RUN, STOPPING} and the `SEQDLY_WIDTH define SHALL reside in PKG_pwm.
REQ-031 The slot down-counter SHALL be a sub-module stagger_timer (reload value, load, tick-out); the FSM stays in the top module.

Verification
REQ-032 chan_en=8'hFF, D=2, start at t=10 -> bit i rises at cycle 11+3i (bit 7 at 32); running=1 from cycle 33.
REQ-033 chan_en=8'b1010_0101, D=0, start -> bits 0,2,5,7 rise at t+1,t+3,t+6,t+8; bits 1,3,4,6 stay 0.
REQ-034 RUN with all bits on, stop, then maskevent_in bits pulsed one per cycle -> each bit clears one cycle after its pulse; done single pulse when entering IDLE, busy falls the same cycle.
REQ-035 stop during STAGGER after 3 slots, chan_en=8'hFF -> bits 3..7 never rise; IDLE after bits 0..2 see maskevent.
REQ-036 abort in RUN and, separately, reset in the cycle bit 4 would rise -> next cycle all outputs 0, IDLE, no done pulse.
REQ-037 start with chan_en=0, start with stop, start while RUN -> state and outputs unchanged.
